issue_station_age: RTL and testbench



---
 rtl/issue_pkg.sv | 10 +
 rtl/age_select.sv | 34 +++
 rtl/issue_station_age.sv | 168 ++++++++++++++++
 tb/tb_issue_station_age.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared helpers for the issue station: derived width computation used by
// the station top and its selection logic.
package issue_pkg;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int id_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/age_select.sv
// One-hot grant over a ready vector. With ISSUE_STATION_AGE_EN the age matrix
// picks the oldest requester; otherwise the lowest-index requester wins.
module age_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]   req,
`ifdef ISSUE_STATION_AGE_EN
    input  logic [N*N-1:0] older,
`endif
    output logic [N-1:0]   grant
);

`ifdef ISSUE_STATION_AGE_EN
    // older[i*N+j] set means entry j is older than entry i.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            grant[i] = req[i];
            for (int j = 0; j < N; j++) begin
                if (req[j] && older[i*N+j]) grant[i] = 1'b0;
            end
        end
    end
`else
    always_comb begin
        logic found;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            grant[i] = req[i] && !found;
            if (req[i]) found = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/issue_station_age.sv
// Reservation station issuing the oldest ready entry (ISSUE_STATION_AGE_EN)
// or the lowest-index ready entry (macro undefined) to one functional unit.
module issue_station_age
    import issue_pkg::*;
#(
    parameter int STATION_SIZE   = 8,
    parameter int INST_ID_BIT    = 8,
    parameter int NUM_REG        = 8,
    parameter int IMM_BIT        = 4,
    parameter int NUM_SRC        = 2,
    parameter int REG_ID_BIT     = id_bits(NUM_REG),
    parameter int STATION_ID_BIT = id_bits(STATION_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [INST_ID_BIT-1:0]        in_id,
    input  logic [REG_ID_BIT-1:0]         in_dst_reg,
    input  logic [NUM_SRC*REG_ID_BIT-1:0] in_src_regs,
    input  logic [IMM_BIT-1:0]            in_imm,
    input  logic [NUM_REG-1:0]            ready_reg_mask,
    input  logic                          flush,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [INST_ID_BIT-1:0]        out_id,
    output logic [REG_ID_BIT-1:0]         out_dst_reg,
    output logic [NUM_SRC*REG_ID_BIT-1:0] out_src_regs,
    output logic [IMM_BIT-1:0]            out_imm,
    output logic [NUM_REG-1:0]            pending_read,
    output logic [STATION_ID_BIT:0]       count,
    output logic                          empty,
    output logic                          full
);

    localparam int CW = STATION_ID_BIT + 1;

    typedef struct packed {
        logic [INST_ID_BIT-1:0]        id;
        logic [REG_ID_BIT-1:0]         dst;
        logic [NUM_SRC*REG_ID_BIT-1:0] srcs;
        logic [IMM_BIT-1:0]            imm;
    } entry_t;

    entry_t                  entry_q [STATION_SIZE];
    entry_t                  entry_d [STATION_SIZE];
    logic [STATION_SIZE-1:0] valid_q, valid_d;
    logic [CW-1:0]           count_q, count_d;

    logic [STATION_SIZE-1:0]   rdy_vec, grant;
    logic [STATION_ID_BIT-1:0] wr_idx, sel_idx;
    logic                      do_wr, do_iss;

    // An entry reading its own destination does not wait on itself.
    always_comb begin
        logic [REG_ID_BIT-1:0] src;
        rdy_vec      = '0;
        pending_read = '0;
        for (int i = 0; i < STATION_SIZE; i++) begin
            rdy_vec[i] = valid_q[i];
            for (int k = 0; k < NUM_SRC; k++) begin
                src = entry_q[i].srcs[k*REG_ID_BIT +: REG_ID_BIT];
                if (!(ready_reg_mask[src] || src == entry_q[i].dst)) rdy_vec[i] = 1'b0;
                if (valid_q[i]) pending_read[src] = 1'b1;
            end
        end
    end

    always_comb begin
        logic found;
        found  = 1'b0;
        wr_idx = '0;
        for (int i = 0; i < STATION_SIZE; i++) begin
            if (!valid_q[i] && !found) begin
                wr_idx = STATION_ID_BIT'(i);
                found  = 1'b1;
            end
        end
    end

`ifdef ISSUE_STATION_AGE_EN
    logic [STATION_SIZE-1:0]              older_q [STATION_SIZE];
    logic [STATION_SIZE-1:0]              older_d [STATION_SIZE];
    logic [STATION_SIZE*STATION_SIZE-1:0] older_flat;

    // A new entry is younger than every entry already valid.
    always_comb begin
        for (int i = 0; i < STATION_SIZE; i++) older_d[i] = older_q[i];
        if (flush) begin
            for (int i = 0; i < STATION_SIZE; i++) older_d[i] = '0;
        end else if (do_wr) begin
            for (int j = 0; j < STATION_SIZE; j++) begin
                older_d[wr_idx][j] = valid_q[j] && (STATION_ID_BIT'(j) != wr_idx);
                older_d[j][wr_idx] = 1'b0;
            end
        end
        for (int i = 0; i < STATION_SIZE; i++) begin
            older_flat[i*STATION_SIZE +: STATION_SIZE] = older_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STATION_SIZE; i++) older_q[i] <= rst ? '0 : older_d[i];
    end
`endif

    age_select #(.N(STATION_SIZE)) u_sel (
        .req   (rdy_vec),
`ifdef ISSUE_STATION_AGE_EN
        .older (older_flat),
`endif
        .grant (grant)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < STATION_SIZE; i++) begin
            if (grant[i]) sel_idx = STATION_ID_BIT'(i);
        end
    end

    assign full         = &valid_q;
    assign empty        = ~|valid_q;
    assign count        = count_q;
    assign in_rdy       = !full;
    assign out_vld      = |rdy_vec;
    assign out_id       = entry_q[sel_idx].id;
    assign out_dst_reg  = entry_q[sel_idx].dst;
    assign out_src_regs = entry_q[sel_idx].srcs;
    assign out_imm      = entry_q[sel_idx].imm;
    assign do_wr        = in_vld && in_rdy;
    assign do_iss       = out_vld && out_rdy;

    // Flush wins over any same-cycle write or issue.
    always_comb begin
        for (int i = 0; i < STATION_SIZE; i++) entry_d[i] = entry_q[i];
        valid_d = valid_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            if (do_wr) begin
                valid_d[wr_idx] = 1'b1;
                entry_d[wr_idx] = '{id: in_id, dst: in_dst_reg, srcs: in_src_regs, imm: in_imm};
            end
            if (do_iss) valid_d[sel_idx] = 1'b0;
            case ({do_wr, do_iss})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < STATION_SIZE; i++) entry_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < STATION_SIZE; i++) entry_q[i] <= entry_d[i];
        end
    end

endmodule

// File: tb/tb_issue_station_age.sv
// Directed bench for issue_station_age: a per-cycle vector table plus
// sequences for full, age ordering, flush and mid-operation reset.
module tb_issue_station_age;

    logic       clk = 1'b0;
    logic       rst, in_vld, in_rdy, flush, out_vld, out_rdy, empty, full;
    logic [7:0] in_id, out_id, ready_reg_mask, pending_read;
    logic [2:0] in_dst_reg, out_dst_reg;
    logic [5:0] in_src_regs, out_src_regs;
    logic [3:0] in_imm, out_imm, count;

    int total = 0;
    int bad   = 0;

    issue_station_age dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_id(in_id),
        .in_dst_reg(in_dst_reg), .in_src_regs(in_src_regs), .in_imm(in_imm),
        .ready_reg_mask(ready_reg_mask), .flush(flush), .out_vld(out_vld),
        .out_rdy(out_rdy), .out_id(out_id), .out_dst_reg(out_dst_reg),
        .out_src_regs(out_src_regs), .out_imm(out_imm), .pending_read(pending_read),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic [2:0] dst, s0, s1;
        logic [7:0] mask;
        logic       ordy;
        int         e_cnt;
        logic       e_empty, e_full, e_inrdy, e_ovld;
        logic [7:0] e_oid, e_pend;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic [2:0] dst,
                                input logic [2:0] s0, input logic [2:0] s1, input logic [7:0] mask,
                                input logic ordy, input int e_cnt, input logic e_full,
                                input logic e_ovld, input logic [7:0] e_oid, input logic [7:0] e_pend);
        vec_t v;
        v.iv = iv; v.id = id; v.dst = dst; v.s0 = s0; v.s1 = s1; v.mask = mask; v.ordy = ordy;
        v.e_cnt = e_cnt; v.e_empty = (e_cnt == 0); v.e_full = e_full; v.e_inrdy = !e_full;
        v.e_ovld = e_ovld; v.e_oid = e_oid; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic [2:0] s0, input logic ordy);
        in_vld      = iv;
        in_id       = id;
        in_dst_reg  = 3'd7;
        in_src_regs = {3'd0, s0};
        in_imm      = id[3:0];
        out_rdy     = ordy;
    endtask

    task automatic expect_issue(input string nm, input logic [7:0] id);
        drive(1'b0, 8'd0, 3'd0, 1'b1);
        #1;
        chk({nm, "_vld"}, out_vld, 1'b1);
        chk({nm, "_id"}, out_id, id);
        step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ready_reg_mask = 8'hFF;
        drive(1'b0, 8'd0, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_in_rdy", in_rdy, 1'b1);
        chk("rst_out_vld", out_vld, 1'b0);
        chk("rst_pending", pending_read, 8'h00);

        //            iv  id  dst s0 s1 mask   ordy cnt full ovld oid  pend
        tbl[0]  = mk(1, 1, 7, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        tbl[1]  = mk(1, 2, 7, 0, 0, 8'hFF, 0, 1, 0, 1, 1, 8'h01);
        tbl[2]  = mk(1, 3, 7, 0, 0, 8'hFF, 0, 2, 0, 1, 1, 8'h01);
        tbl[3]  = mk(0, 0, 7, 0, 0, 8'hFF, 0, 3, 0, 1, 1, 8'h01);
        tbl[4]  = mk(0, 0, 7, 0, 0, 8'hFF, 1, 3, 0, 1, 1, 8'h01);
        tbl[5]  = mk(0, 0, 7, 0, 0, 8'hFF, 1, 2, 0, 1, 2, 8'h01);
        tbl[6]  = mk(0, 0, 7, 0, 0, 8'hFF, 1, 1, 0, 1, 3, 8'h01);
        tbl[7]  = mk(0, 0, 7, 0, 0, 8'hFF, 1, 0, 0, 0, 0, 8'h00);
        tbl[8]  = mk(1, 4, 7, 3, 0, 8'hF7, 1, 0, 0, 0, 0, 8'h00);
        tbl[9]  = mk(0, 0, 7, 0, 0, 8'hF7, 1, 1, 0, 0, 0, 8'h09);
        tbl[10] = mk(0, 0, 7, 0, 0, 8'hFF, 1, 1, 0, 1, 4, 8'h09);
        tbl[11] = mk(0, 0, 7, 0, 0, 8'hFF, 1, 0, 0, 0, 0, 8'h00);
        tbl[12] = mk(1, 5, 6, 6, 6, 8'hBF, 1, 0, 0, 0, 0, 8'h00);
        tbl[13] = mk(0, 0, 7, 0, 0, 8'hBF, 1, 1, 0, 1, 5, 8'h40);
        tbl[14] = mk(0, 0, 7, 0, 0, 8'hFF, 1, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 15; i++) begin
            in_vld         = tbl[i].iv;
            in_id          = tbl[i].id;
            in_dst_reg     = tbl[i].dst;
            in_src_regs    = {tbl[i].s1, tbl[i].s0};
            in_imm         = tbl[i].id[3:0];
            ready_reg_mask = tbl[i].mask;
            out_rdy        = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
            chk($sformatf("v%0d_empty", i), empty, tbl[i].e_empty);
            chk($sformatf("v%0d_full", i), full, tbl[i].e_full);
            chk($sformatf("v%0d_in_rdy", i), in_rdy, tbl[i].e_inrdy);
            chk($sformatf("v%0d_out_vld", i), out_vld, tbl[i].e_ovld);
            chk($sformatf("v%0d_pending", i), pending_read, tbl[i].e_pend);
            if (tbl[i].e_ovld) begin
                chk($sformatf("v%0d_out_id", i), out_id, tbl[i].e_oid);
                chk($sformatf("v%0d_out_imm", i), out_imm, tbl[i].e_oid[3:0]);
            end
            step();
        end

        // Fill to capacity, then offer a write alongside an issue.
        ready_reg_mask = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(10 + i), 3'd0, 1'b0);
            step();
        end
        drive(1'b0, 8'd0, 3'd0, 1'b0);
        #1;
        chk("full_count", count, 8);
        chk("full_flag", full, 1'b1);
        chk("full_in_rdy", in_rdy, 1'b0);
        drive(1'b1, 8'd99, 3'd0, 1'b1);
        #1;
        chk("full_iss_id", out_id, 8'd10);
        step();
        drive(1'b0, 8'd0, 3'd0, 1'b0);
        #1;
        chk("after_full_count", count, 7);
        chk("after_full_in_rdy", in_rdy, 1'b1);
        chk("after_full_flag", full, 1'b0);
        for (int i = 11; i < 18; i++) expect_issue($sformatf("drain%0d", i), 8'(i));
        #1;
        chk("drain_empty", empty, 1'b1);

        // Age order: slot 0 is refilled by the youngest entry.
        ready_reg_mask = 8'hFD;
        drive(1'b1, 8'd20, 3'd0, 1'b0);
        step();
        for (int i = 21; i < 24; i++) begin
            drive(1'b1, 8'(i), 3'd1, 1'b0);
            step();
        end
        expect_issue("age_first", 8'd20);
        drive(1'b1, 8'd9, 3'd1, 1'b0);
        #1;
        chk("age_blocked", out_vld, 1'b0);
        step();
        ready_reg_mask = 8'hFF;
`ifdef ISSUE_STATION_AGE_EN
        expect_issue("age_o0", 8'd21);
        expect_issue("age_o1", 8'd22);
        expect_issue("age_o2", 8'd23);
        expect_issue("age_o3", 8'd9);
`else
        expect_issue("age_o0", 8'd9);
        expect_issue("age_o1", 8'd21);
        expect_issue("age_o2", 8'd22);
        expect_issue("age_o3", 8'd23);
`endif

        // Flush overrides a simultaneous write and issue.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(30 + i), 3'd2, 1'b0);
            step();
        end
        drive(1'b1, 8'd40, 3'd0, 1'b1);
        flush = 1'b1;
        #1;
        chk("pre_flush_count", count, 5);
        chk("pre_flush_pending", pending_read, 8'h05);
        step();
        flush = 1'b0;
        drive(1'b0, 8'd0, 3'd0, 1'b0);
        #1;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1'b1);
        chk("flush_pending", pending_read, 8'h00);
        chk("flush_out_vld", out_vld, 1'b0);
        drive(1'b1, 8'd41, 3'd0, 1'b0);
        step();
        expect_issue("post_flush", 8'd41);

        // Reset in the middle of operation.
        drive(1'b1, 8'd50, 3'd4, 1'b0);
        step();
        drive(1'b1, 8'd51, 3'd5, 1'b0);
        step();
        drive(1'b0, 8'd0, 3'd0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_pending", pending_read, 8'h00);
        chk("midrst_out_vld", out_vld, 1'b0);
        chk("midrst_in_rdy", in_rdy, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
